// File: rtl/pattern_detector_fsm.sv
// Bit-serial Moore pattern detector: programmable pattern, overlap mode, input qualifier and
// saturating match counter. Define PATDET_MASK_EN to add a per-bit don't-care mask (pat_mask).
module pattern_detector_fsm #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b0101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef PATDET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             overlap,
    input  logic             a_valid,
    input  logic             a,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_y;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic [PAT_W-1:0]  w_hist_next;
    logic [FILL_W-1:0] w_fill_inc;
    logic [FILL_W-1:0] w_fill_next;
    logic [PAT_W-1:0]  w_care;
    logic              w_match;
    logic              w_hit;
    logic              w_cnt_full;

`ifdef PATDET_MASK_EN
    logic [PAT_W-1:0]  r_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (pat_load) begin
            r_mask <= pat_mask;
        end
    end

    assign w_care = ~r_mask;
`else
    assign w_care = '1;
`endif

    // A bit is only taken when no pattern load competes for the same cycle.
    assign w_accept    = a_valid & ~pat_load;
    assign w_hist_next = {r_hist[PAT_W-2:0], a};
    assign w_fill_inc  = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + FILL_ONE);
    // Non-overlapping: after a reported match, the current bit starts a fresh window.
    assign w_fill_next = (!overlap && r_y) ? FILL_ONE : w_fill_inc;
    assign w_match     = (w_fill_next == FILL_FULL) &&
                         (((w_hist_next ^ r_pat) & w_care) == '0);
    assign w_hit       = w_accept & w_match;
    assign w_cnt_full  = &r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat  <= RST_PAT;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (a_valid) begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
            r_y    <= w_match;
        end
    end

    // Clear takes effect first, so a coincident match leaves the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && !w_cnt_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign y         = r_y;
    assign match_cnt = r_cnt;
    assign cnt_sat   = w_cnt_full;

endmodule

// File: tb/tb_pattern_detector_fsm.sv
// Directed bench for pattern_detector_fsm: default-width counter instance plus a 2-bit counter
// instance driven by the same stimulus.
module tb_pattern_detector_fsm;

    logic       clk;
    logic       reset;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       overlap;
    logic       a_valid;
    logic       a;
    logic       cnt_clr;
`ifdef PATDET_MASK_EN
    logic [3:0] pat_mask;
`endif

    logic       y_a;
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       y_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    int total = 0;
    int bad   = 0;

    pattern_detector_fsm #(.PAT_W(4), .RST_PAT(4'b0101), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
`ifdef PATDET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .overlap(overlap), .a_valid(a_valid), .a(a), .cnt_clr(cnt_clr),
        .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    pattern_detector_fsm #(.PAT_W(4), .RST_PAT(4'b0101), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
`ifdef PATDET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .overlap(overlap), .a_valid(a_valid), .a(a), .cnt_clr(cnt_clr),
        .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic clr);
        a_valid = 1'b1;
        a       = b;
        cnt_clr = clr;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] p);
        pat_load = 1'b1;
        pat_in   = p;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
    endtask

    task automatic clear();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    // Sends the low n bits of 'bits' MSB first and checks y after each against 'yexp'.
    task automatic run_seq(input string tag, input logic [15:0] bits,
                           input logic [15:0] yexp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], 1'b0);
            chk($sformatf("%s_y%0d", tag, n - i), {31'd0, y_a}, {31'd0, yexp[i]});
        end
    endtask

    initial begin
        reset    = 1'b1;
        pat_load = 1'b0;
        pat_in   = 4'd0;
        overlap  = 1'b1;
        a_valid  = 1'b0;
        a        = 1'b0;
        cnt_clr  = 1'b0;
`ifdef PATDET_MASK_EN
        pat_mask = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", {31'd0, y_a}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
        chk("rst_sat_a", {31'd0, sat_a}, 32'd0);
        chk("rst_sat_b", {31'd0, sat_b}, 32'd0);
        reset = 1'b0;
        idle(1);

        // Overlapping detection of 0110
        load(4'b0110);
        overlap = 1'b1;
        run_seq("ovl", 16'b0110110, 16'b0001001, 7);
        chk("ovl_cnt", {24'd0, cnt_a}, 32'd2);
        chk("ovl_cnt_b", {30'd0, cnt_b}, 32'd2);
        chk("ovl_sat_b", {31'd0, sat_b}, 32'd0);

        // Non-overlapping detection of 0110
        load(4'b0110);
        clear();
        chk("clr_cnt", {24'd0, cnt_a}, 32'd0);
        overlap = 1'b0;
        run_seq("novl", 16'b0110110, 16'b0001000, 7);
        chk("novl_cnt", {24'd0, cnt_a}, 32'd1);

        // Gapped stream: y holds across idle cycles
        load(4'b0110);
        clear();
        overlap = 1'b1;
        send(1'b0, 1'b0); chk("gap_y1", {31'd0, y_a}, 32'd0);
        idle(3);          chk("gap_h1", {31'd0, y_a}, 32'd0);
        send(1'b1, 1'b0); chk("gap_y2", {31'd0, y_a}, 32'd0);
        idle(3);          chk("gap_h2", {31'd0, y_a}, 32'd0);
        send(1'b1, 1'b0); chk("gap_y3", {31'd0, y_a}, 32'd0);
        idle(3);          chk("gap_h3", {31'd0, y_a}, 32'd0);
        send(1'b0, 1'b0); chk("gap_y4", {31'd0, y_a}, 32'd1);
        idle(3);          chk("gap_h4", {31'd0, y_a}, 32'd1);
        chk("gap_cnt_h", {24'd0, cnt_a}, 32'd1);
        send(1'b1, 1'b0); chk("gap_y5", {31'd0, y_a}, 32'd0);
        chk("gap_cnt", {24'd0, cnt_a}, 32'd1);

        // Saturation of the 2-bit counter, then clear with a coincident match
        load(4'b0101);
        clear();
        overlap = 1'b1;
        run_seq("sat", 16'b01010101, 16'b00010101, 8);
        chk("sat_cnt_b", {30'd0, cnt_b}, 32'd3);
        chk("sat_flag_b", {31'd0, sat_b}, 32'd1);
        chk("sat_cnt_a", {24'd0, cnt_a}, 32'd3);
        chk("sat_flag_a", {31'd0, sat_a}, 32'd0);
        run_seq("sath", 16'b01, 16'b01, 2);
        chk("sath_cnt_b", {30'd0, cnt_b}, 32'd3);
        chk("sath_cnt_a", {24'd0, cnt_a}, 32'd4);
        send(1'b0, 1'b0);
        chk("clrm_y0", {31'd0, y_a}, 32'd0);
        send(1'b1, 1'b1);
        chk("clrm_y1", {31'd0, y_a}, 32'd1);
        chk("clrm_cnt_b", {30'd0, cnt_b}, 32'd1);
        chk("clrm_cnt_a", {24'd0, cnt_a}, 32'd1);
        chk("clrm_sat_b", {31'd0, sat_b}, 32'd0);

        // pat_load wins over a coincident valid bit
        load(4'b0110);
        run_seq("pre", 16'b011, 16'b000, 3);
        pat_load = 1'b1;
        pat_in   = 4'b1001;
        a_valid  = 1'b1;
        a        = 1'b0;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        a_valid  = 1'b0;
        chk("pl_y", {31'd0, y_a}, 32'd0);
        chk("pl_cnt", {24'd0, cnt_a}, 32'd1);
        run_seq("pl", 16'b001001, 16'b000001, 6);
        chk("pl_cnt2", {24'd0, cnt_a}, 32'd2);
        chk("pl_cnt2_b", {30'd0, cnt_b}, 32'd2);

        // Asynchronous reset mid-pattern
        run_seq("mid", 16'b100, 16'b000, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_y", {31'd0, y_a}, 32'd0);
        chk("arst_cnt", {24'd0, cnt_a}, 32'd0);
        chk("arst_cnt_b", {30'd0, cnt_b}, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_seq("post", 16'b0101, 16'b0001, 4);
        chk("post_cnt", {24'd0, cnt_a}, 32'd1);

        // Degenerate all-ones pattern
        load(4'b1111);
        overlap = 1'b1;
        run_seq("ones", 16'b11111, 16'b00011, 5);
        chk("ones_cnt", {24'd0, cnt_a}, 32'd3);
        chk("ones_sat_b", {31'd0, sat_b}, 32'd1);
        overlap = 1'b0;
        send(1'b1, 1'b0);
        chk("ones_novl_y", {31'd0, y_a}, 32'd0);
        chk("ones_novl_cnt", {24'd0, cnt_a}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
